// File: rtl/uart_word_loader.sv
// UART receiver that assembles multi-byte words and writes them to
// per-channel address streams; build with UART_PARITY_EN for 8E1 framing.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   rx_in           asynchronous serial line, idle high
//   ch_sel          destination channel, sampled at the first start bit
//   wr_en           one-cycle write strobe with wr_ch / wr_addr / wr_data
//   frame_err       pulse on a low stop bit
//   timeout_err     pulse when a partial word is dropped after idling
//   parity_err      pulse on even-parity mismatch (0 without the macro)
//   busy            receiving, or a partial word is held
module uart_word_loader #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int WORD_BYTES   = 2,
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 8,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int TIMEOUT_BITS = 20,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DW = 8 * WORD_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  input  logic [CW-1:0]     ch_sel,
  output logic              wr_en,
  output logic [CW-1:0]     wr_ch,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              frame_err,
  output logic              timeout_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW  = $clog2(TLIM + 1);

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BAUD_HALF = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]  BYTE_LAST = BW'(WORD_BYTES - 1);
  localparam logic [TW-1:0]  TOUT_LAST = TW'(TLIM);
  localparam logic [CW:0]    NCH_W     = (CW + 1)'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t state_q, state_d;

  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic rx_sync;

  logic [BCW-1:0]    baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DW-1:0]     word_q, word_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [ADDR_W-1:0] addr_d [NUM_CH];

  logic              wr_en_q, wr_en_d;
  logic [CW-1:0]     wr_ch_q, wr_ch_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic              ferr_q, ferr_d;
  logic              terr_q, terr_d;

`ifdef UART_PARITY_EN
  logic perr_q, perr_d;
  logic pbad_q, pbad_d;
`endif

  logic [DW-1:0] word_new;
  logic          ch_ok;
  int            lane;

  assign rx_sync = rx_s2_q;
  assign ch_ok   = (ch_q != '0) && ({1'b0, ch_q} < NCH_W);

  // Lane for the byte now arriving, from its position in the word.
  always_comb begin
    lane = MSB_FIRST ? (WORD_BYTES - 1 - int'(bcnt_q))
                     : int'(bcnt_q);
    word_new = word_q;
    word_new[lane*8 +: 8] = shift_q;
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    ch_d      = ch_q;
    idle_d    = '0;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_ch_d   = wr_ch_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ferr_d    = 1'b0;
    terr_d    = 1'b0;
`ifdef UART_PARITY_EN
    perr_d    = 1'b0;
    pbad_d    = pbad_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (bcnt_q != '0) begin
          if (idle_q == TOUT_LAST) begin
            terr_d = 1'b1;
            bcnt_d = '0;
            word_d = '0;
          end else begin
            idle_d = idle_q + TW'(1);
          end
        end
        if (rx_prev_q && !rx_sync) state_d = S_START;
      end

      // Mid-start re-check filters glitches on the line.
      S_START: begin
        if (baud_q == BAUD_HALF) begin
          baud_d = '0;
          if (rx_sync) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            if (bcnt_q == '0) ch_d = ch_sel;
          end
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end

      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end

`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          pbad_d  = rx_sync ^ (^shift_q);
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end
`endif

      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (!rx_sync) begin
            ferr_d  = 1'b1;
            bcnt_d  = '0;
            word_d  = '0;
            state_d = S_BREAK;
`ifdef UART_PARITY_EN
          end else if (pbad_q) begin
            perr_d  = 1'b1;
            bcnt_d  = '0;
            word_d  = '0;
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_IDLE;
            if (bcnt_q == BYTE_LAST) begin
              bcnt_d = '0;
              word_d = '0;
              if (ch_ok) begin
                wr_en_d      = 1'b1;
                wr_ch_d      = ch_q;
                wr_addr_d    = addr_q[ch_q];
                wr_data_d    = word_new;
                addr_d[ch_q] = addr_q[ch_q] + ADDR_W'(1);
              end
            end else begin
              bcnt_d = bcnt_q + BW'(1);
              word_d = word_new;
            end
          end
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end

      // After a framing error, hold off until the line returns high.
      S_BREAK: begin
        if (rx_sync) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      bcnt_q    <= '0;
      word_q    <= '0;
      ch_q      <= '0;
      idle_q    <= '0;
      addr_q    <= '{default: '0};
      wr_en_q   <= 1'b0;
      wr_ch_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ferr_q    <= 1'b0;
      terr_q    <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q    <= 1'b0;
      pbad_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      bcnt_q    <= bcnt_d;
      word_q    <= word_d;
      ch_q      <= ch_d;
      idle_q    <= idle_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_ch_q   <= wr_ch_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ferr_q    <= ferr_d;
      terr_q    <= terr_d;
`ifdef UART_PARITY_EN
      perr_q    <= perr_d;
      pbad_q    <= pbad_d;
`endif
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_ch       = wr_ch_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;
`ifdef UART_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif
  assign busy = (state_q != S_IDLE) || (bcnt_q != '0);

endmodule

// File: tb/tb_uart_word_loader.sv
// Randomized bench for uart_word_loader against a byte-stream model.
// Expected writes are queued by the model and matched by a monitor.
module tb_uart_word_loader;

  localparam int CPB   = 16;
  localparam int WB    = 2;
  localparam int AW    = 2;
  localparam int TOUTB = 20;
  localparam bit MSBF  = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_in = 1'b1;
  logic [1:0]  ch_sel = '0;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [AW-1:0] wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic        timeout_err;
  logic        parity_err;
  logic        busy;

  uart_word_loader #(
    .CLKS_PER_BIT(CPB),
    .WORD_BYTES(WB),
    .NUM_CH(3),
    .ADDR_W(AW),
    .MSB_FIRST(MSBF),
    .TIMEOUT_BITS(TOUTB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_in(rx_in),
    .ch_sel(ch_sel),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_err(frame_err),
    .timeout_err(timeout_err),
    .parity_err(parity_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int addr;
    int data;
  } wr_t;

  wr_t  exp_q[$];
  int   partial[$];
  int   m_addr[3];
  int   m_ch;
  int   exp_ferr, exp_terr, exp_perr;
  int   got_ferr, got_terr, got_perr;
  int   n_chk, n_fail;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        check("wr_vs_ferr", {31'd0, frame_err}, 0);
        if (exp_q.size() == 0) begin
          check("wr_unexpected", {31'd0, wr_en}, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_ch", {30'd0, wr_ch}, e.ch);
          check("wr_addr", {30'd0, wr_addr}, e.addr);
          check("wr_data", {16'd0, wr_data}, e.data);
        end
      end
      if (frame_err) got_ferr++;
      if (timeout_err) got_terr++;
      if (parity_err) got_perr++;
    end
  end

  task automatic model_clear();
    partial.delete();
    for (int i = 0; i < 3; i++) m_addr[i] = 0;
  endtask

  // Byte-level model: collect bytes, emit a word when complete.
  task automatic model_byte(input int b);
    int w;
    wr_t e;
    partial.push_back(b);
    if (partial.size() == WB) begin
      w = 0;
      for (int k = 0; k < WB; k++) begin
        if (MSBF) w = (w << 8) | partial[k];
        else w = w | (partial[k] << (8 * k));
      end
      if (m_ch != 0) begin
        e.ch = m_ch;
        e.addr = m_addr[m_ch];
        e.data = w;
        exp_q.push_back(e);
        m_addr[m_ch] = (m_addr[m_ch] + 1) % (1 << AW);
      end
      partial.delete();
    end
  endtask

  task automatic bit_out(input logic v);
    rx_in = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    if (n > TOUTB && partial.size() != 0) begin
      exp_terr++;
      partial.delete();
    end
    rx_in = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit stop,
                           input bit pflip);
    bit perr;
    perr = 1'b0;
    if (partial.size() == 0) m_ch = int'(ch_sel);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_PARITY_EN
    perr = pflip;
    bit_out((^b) ^ pflip);
`endif
    if (!stop) begin
      exp_ferr++;
      partial.delete();
    end else if (perr) begin
      exp_perr++;
      partial.delete();
    end else begin
      model_byte(int'(b));
    end
    bit_out(stop);
    rx_in = 1'b1;
  endtask

  task automatic send_word(input int ch, input logic [15:0] w);
    ch_sel = 2'(ch);
    send_byte(w[15:8], 1'b1, 1'b0);
    ch_sel = 2'($urandom_range(0, 2));
    idle_bits($urandom_range(0, 3));
    send_byte(w[7:0], 1'b1, 1'b0);
    idle_bits($urandom_range(1, 3));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_ferr = 0;
    exp_terr = 0;
    exp_perr = 0;
    got_ferr = 0;
    got_terr = 0;
    got_perr = 0;
    m_ch = 0;
    model_clear();

    do_reset();
    check("rst_wr_en", {31'd0, wr_en}, 0);
    check("rst_wr_ch", {30'd0, wr_ch}, 0);
    check("rst_wr_addr", {30'd0, wr_addr}, 0);
    check("rst_wr_data", {16'd0, wr_data}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    check("rst_terr", {31'd0, timeout_err}, 0);
    check("rst_perr", {31'd0, parity_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    idle_bits(2);

    send_word(1, 16'h20F2);
    send_word(1, 16'h1104);
    send_word(2, 16'h0064);
    send_word(2, 16'h00C8);
    send_word(1, 16'h3344);

    ch_sel = 2'd1;
    send_byte(8'h12, 1'b0, 1'b0);
    idle_bits(2);
    check("ferr_cnt", got_ferr, exp_ferr);
    send_word(1, 16'hABCD);

    ch_sel = 2'd2;
    send_byte(8'h55, 1'b1, 1'b0);
    idle_bits(1);
    check("busy_partial", {31'd0, busy}, 1);
    idle_bits(21);
    check("terr_cnt", got_terr, exp_terr);
    check("busy_after_to", {31'd0, busy}, 0);
    send_word(2, 16'h0102);

    for (int i = 0; i < 5; i++) send_word(1, 16'(16'h0A00 + i));
    send_word(0, 16'hDEAD);

    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    idle_bits(2);
    check("glitch_busy", {31'd0, busy}, 0);
    check("glitch_ferr", got_ferr, exp_ferr);

    ch_sel = 2'd1;
    send_byte(8'h99, 1'b1, 1'b0);
    idle_bits(1);
    do_reset();
    check("rst_mid_busy", {31'd0, busy}, 0);
    idle_bits(2);
    send_word(1, 16'h4242);

`ifdef UART_PARITY_EN
    ch_sel = 2'd1;
    send_byte(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    check("perr_cnt", got_perr, exp_perr);
    send_word(1, 16'h5A5A);
`endif

    for (int i = 0; i < 24; i++) begin
      int ch;
      logic [7:0] b;
      bit bad;
      ch = $urandom_range(0, 2);
      ch_sel = 2'(ch);
      for (int k = 0; k < WB; k++) begin
        b = 8'($urandom);
        bad = ($urandom_range(0, 9) == 0);
        send_byte(b, !bad, 1'b0);
        ch_sel = 2'($urandom_range(0, 2));
        idle_bits($urandom_range(1, 3));
        if (bad) break;
      end
    end

    idle_bits(4);
    check("exp_q_empty", exp_q.size(), 0);
    check("ferr_total", got_ferr, exp_ferr);
    check("terr_total", got_terr, exp_terr);
    check("perr_total", got_perr, exp_perr);
    check("busy_end", {31'd0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_word_loader.md
UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning clk cycles per UART bit (100 MHz / 9600 baud).
REQ-002 SHALL have parameter WORD_BYTES, default 2, meaning bytes per assembled word (range 1..4); DW = 8*WORD_BYTES.
REQ-003 SHALL have parameter NUM_CH, default 3, meaning channel count including channel 0 (discard); CW = clog2(NUM_CH).
REQ-004 SHALL have parameter ADDR_W, default 8, meaning per-channel write-address width.
REQ-005 SHALL have parameter MSB_FIRST, default 1, meaning first received byte lands in the most significant byte; 0 means least significant.
REQ-006 SHALL have parameter TIMEOUT_BITS, default 20, meaning the inter-byte idle limit in bit times.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port rx_in  input  1  asynchronous UART serial line, idle high.
REQ-010 SHALL have port ch_sel  input  CW  destination channel for the next word.
REQ-011 SHALL have port wr_en  output  1  one-cycle word-write strobe.
REQ-012 SHALL have port wr_ch  output  CW  channel of the written word.
REQ-013 SHALL have port wr_addr  output  ADDR_W  word address within the channel.
REQ-014 SHALL have port wr_data  output  DW  assembled word.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-016 SHALL have port timeout_err  output  1  one-cycle pulse when a partial word is dropped.
REQ-017 SHALL have port parity_err  output  1  one-cycle pulse on a parity mismatch.
REQ-018 SHALL have port busy  output  1  high whenever not IDLE or a partial word is held.

Function
REQ-019 SHALL pass rx_in through a 2-flop synchronizer before any use.
REQ-020 SHALL implement FSM IDLE->START->DATA->(PARITY)->STOP->IDLE, with a bit counter 0..7 and a baud counter 0..CLKS_PER_BIT-1.
REQ-021 SHALL leave IDLE on a synchronized falling edge, and SHALL re-check the line at CLKS_PER_BIT/2; if the line is high, it SHALL return to IDLE with no error (glitch).
REQ-022 SHALL sample data bits LSB-first at mid-bit, then the stop bit at mid-bit.
REQ-023 SHALL latch ch_sel at the validated start bit of the first byte of each word; ch_sel changes mid-word SHALL be ignored.
REQ-024 SHALL place byte k (0-based arrival order) at byte lane WORD_BYTES-1-k when MSB_FIRST=1, else at lane k.
REQ-025 SHALL, after the stop bit of the last byte of a word is sampled high, assert wr_en for exactly 1 cycle on the next clk, with wr_ch, wr_addr and wr_data valid in that cycle.
REQ-026 SHALL increment the selected channel's address counter after each write, wrapping from 2^ADDR_W-1 to 0.
REQ-027 SHALL, for a completed word whose latched channel is 0, produce no wr_en and advance no counter.
REQ-028 SHALL, on a stop bit sampled low: pulse frame_err, discard the partial word and byte, and wait for the line to go high before entering IDLE.
REQ-029 SHALL, when a partial word is held and the line idles for more than TIMEOUT_BITS*CLKS_PER_BIT cycles: pulse timeout_err, discard the partial word, and leave counters unchanged.
REQ-030 SHALL never assert frame_err and wr_en in the same cycle; at most one error pulse SHALL occur per byte.

Reset
REQ-031 SHALL, while reset is high at a clk edge, force: FSM=IDLE; all counters and address counters=0; wr_en, frame_err, timeout_err and parity_err=0; busy=0; wr_ch, wr_addr and wr_data=0.
REQ-032 SHALL, on reset mid-frame or mid-word, discard the partial data; the next byte SHALL start a new word.

Configuration
REQ-033 SHALL use macro UART_PARITY_EN; when defined, SHALL expect one even-parity bit after bit 7 (PARITY state), and on mismatch SHALL pulse parity_err and discard as in REQ-028 after the stop bit.
REQ-034 SHALL, when UART_PARITY_EN is undefined, use 8N1 framing with no PARITY state and parity_err tied to 0.

Verification (CLKS_PER_BIT=16, defaults otherwise)
REQ-035 SHALL cover: ch_sel=1, bytes 0x20 then 0xF2 -> one wr_en, wr_ch=1, wr_addr=0, wr_data=0x20F2; next word 0x1104 -> wr_addr=1.
REQ-036 SHALL cover: ch_sel=2, words 0x0064 then 0x00C8 -> wr_ch=2, addresses 0 then 1; channel 1 counter unaffected.
REQ-037 SHALL cover: byte 0x12 with stop bit=0 -> frame_err pulse, no wr_en; next word 0xABCD -> written intact.
REQ-038 SHALL cover: one byte 0x55, then idle 21 bit times -> timeout_err pulse; next bytes 0x01,0x02 -> wr_data=0x0102.
REQ-039 SHALL cover: ADDR_W=2, five words on ch 1 -> addresses 0,1,2,3,0; ch_sel=0 word -> no wr_en.
REQ-040 SHALL cover: UART_PARITY_EN defined, byte 0x07 with parity bit 0 -> parity_err pulse, no write.
